// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - RV32I 5-stage hazard, flush, forwarding and dmem-wait controller
// Optional feature macro: PERF_CNT_EN (performance counters for mem stall, load-use stall, flush)
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             load_e,
  input  logic             RegWrite_m,
  input  logic             RegWrite_w,
  input  logic             PCSrc_e,
  input  logic             mem_access_m,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             clr_fd,
  output logic             clr_de,
  output logic             clr_em,
  output logic             clr_mw,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_mem_stall,
  output logic [CNT_W-1:0] cnt_lu_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  typedef enum logic [1:0] {IDLE, WAIT, HALT} state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;

  logic in_halt;
  logic mem_stall;
  logic lu_hazard;
  logic do_flush;
  logic do_lu;

  // Hazard classification in priority order: halt, memory stall, flush, load-use
  always_comb begin
    in_halt   = (state == HALT);
    mem_stall = mem_access_m & ~dmem_ready & ~in_halt;
    lu_hazard = load_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
    do_flush  = ~in_halt & ~mem_stall & PCSrc_e;
    do_lu     = ~in_halt & ~mem_stall & ~PCSrc_e & lu_hazard;
  end

  // Pipeline register enables/clears and PC stall; reset holds the pipe in its free-running form
  always_comb begin
    en_fd    = 1'b1;
    en_de    = 1'b1;
    en_em    = 1'b1;
    en_mw    = 1'b1;
    clr_fd   = 1'b0;
    clr_de   = 1'b0;
    clr_em   = 1'b0;
    clr_mw   = 1'b0;
    stall_f  = 1'b0;
    dmem_req = 1'b0;
    if (rst_n) begin
      dmem_req = mem_access_m & ~in_halt;
      if (in_halt || mem_stall) begin
        en_fd   = 1'b0;
        en_de   = 1'b0;
        en_em   = 1'b0;
        en_mw   = 1'b0;
        stall_f = 1'b1;
      end else if (do_flush) begin
        clr_fd = 1'b1;
        clr_de = 1'b1;
      end else if (do_lu) begin
        stall_f = 1'b1;
        en_fd   = 1'b0;
        clr_de  = 1'b1;
      end
    end
  end

  // E-stage operand forwarding; the younger M result wins over W
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (rst_n) begin
      if (RegWrite_m && rd_m != 5'd0 && rd_m == rs1_e)      forward_a_e = 2'b10;
      else if (RegWrite_w && rd_w != 5'd0 && rd_w == rs1_e) forward_a_e = 2'b01;
      if (RegWrite_m && rd_m != 5'd0 && rd_m == rs2_e)      forward_b_e = 2'b10;
      else if (RegWrite_w && rd_w != 5'd0 && rd_w == rs2_e) forward_b_e = 2'b01;
    end
  end

  // Data-memory wait FSM; to_cnt counts stalled cycles so the 17th unanswered cycle halts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      to_cnt <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_stall) begin
            state  <= WAIT;
            to_cnt <= TO_W'(1);
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            state  <= IDLE;
            to_cnt <= '0;
          end else if (to_cnt == TO_W'(MEM_TIMEOUT)) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          to_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Performance counters; halt implies no stall/flush/load-use events so they freeze there
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_mem_stall <= '0;
      cnt_lu_stall  <= '0;
      cnt_flush     <= '0;
    end else begin
      if (mem_stall) cnt_mem_stall <= cnt_mem_stall + CNT_W'(1);
      if (do_lu)     cnt_lu_stall  <= cnt_lu_stall + CNT_W'(1);
      if (do_flush)  cnt_flush     <= cnt_flush + CNT_W'(1);
    end
  end
`else
  // Counters not built: outputs tied off
  always_comb begin
    cnt_mem_stall = '0;
    cnt_lu_stall  = '0;
    cnt_flush     = '0;
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        load_e, RegWrite_m, RegWrite_w, PCSrc_e, mem_access_m, dmem_ready;
  logic        dmem_req, stall_f, halted;
  logic [1:0]  forward_a_e, forward_b_e;
  logic        en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw;
  logic [31:0] cnt_mem_stall, cnt_lu_stall, cnt_flush;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] en;
    logic [3:0] clr;
    logic       st;
    logic       rq;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       h;
    int         cms;
    int         clu;
    int         cfl;
  } exp_t;

  exp_t sb[$];

  pipeline_ctrl #(.MEM_TIMEOUT(16), .TO_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .load_e(load_e), .RegWrite_m(RegWrite_m), .RegWrite_w(RegWrite_w),
    .PCSrc_e(PCSrc_e), .mem_access_m(mem_access_m), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
    .clr_fd(clr_fd), .clr_de(clr_de), .clr_em(clr_em), .clr_mw(clr_mw),
    .halted(halted), .cnt_mem_stall(cnt_mem_stall), .cnt_lu_stall(cnt_lu_stall),
    .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  function automatic int pc(input int v);
`ifdef PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents controls; compare against the queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("en", int'({en_fd, en_de, en_em, en_mw}), int'(e.en));
      chk("clr", int'({clr_fd, clr_de, clr_em, clr_mw}), int'(e.clr));
      chk("stall_f", int'(stall_f), int'(e.st));
      chk("dmem_req", int'(dmem_req), int'(e.rq));
      chk("forward_a_e", int'(forward_a_e), int'(e.fa));
      chk("forward_b_e", int'(forward_b_e), int'(e.fb));
      chk("halted", int'(halted), int'(e.h));
      chk("cnt_mem_stall", int'(cnt_mem_stall), pc(e.cms));
      chk("cnt_lu_stall", int'(cnt_lu_stall), pc(e.clu));
      chk("cnt_flush", int'(cnt_flush), pc(e.cfl));
    end
  end

  task automatic step(input logic [3:0] en, input logic [3:0] clr, input logic st, input logic rq,
                      input logic [1:0] fa, input logic [1:0] fb, input logic h,
                      input int cms, input int clu, input int cfl);
    exp_t e;
    e.en = en; e.clr = clr; e.st = st; e.rq = rq; e.fa = fa; e.fb = fb; e.h = h;
    e.cms = cms; e.clu = clu; e.cfl = cfl;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic clear_in();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    load_e = 0; RegWrite_m = 0; RegWrite_w = 0; PCSrc_e = 0; mem_access_m = 0; dmem_ready = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    // Hostile inputs during reset must not leak to the controls
    mem_access_m = 1; PCSrc_e = 1; load_e = 1; rd_e = 5; rs1_d = 5;
    rd_m = 7; RegWrite_m = 1; rs1_e = 7;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(4'b1111, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);

    rst_n = 1'b1; clear_in();
    step(4'b1111, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    // Load-use on rs1
    load_e = 1; rd_e = 5; rs1_d = 5;
    step(4'b0111, 4'b0100, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    clear_in();
    step(4'b1111, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    // x0 destination never stalls
    load_e = 1; rd_e = 0; rs1_d = 0; rs2_d = 0;
    step(4'b1111, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    // Non-load match does not stall
    load_e = 0; rd_e = 6; rs2_d = 6;
    step(4'b1111, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    // Load-use on rs2
    load_e = 1;
    step(4'b0111, 4'b0100, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    clear_in();
    // Forwarding: M beats W on A, B untouched
    rd_m = 7; rd_w = 7; RegWrite_m = 1; RegWrite_w = 1; rs1_e = 7; rs2_e = 0;
    step(4'b1111, 4'b0000, 0, 0, 2'b10, 2'b00, 0, 0, 2, 0);
    RegWrite_m = 0;
    step(4'b1111, 4'b0000, 0, 0, 2'b01, 2'b00, 0, 0, 2, 0);
    rs1_e = 0; rs2_e = 9; rd_m = 9; rd_w = 9; RegWrite_m = 1;
    step(4'b1111, 4'b0000, 0, 0, 2'b00, 2'b10, 0, 0, 2, 0);
    rs2_e = 0; rd_m = 0; rd_w = 0;
    step(4'b1111, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0, 2, 0);
    // Forwarding stays active during a load-use stall
    rs1_e = 7; rd_m = 7; load_e = 1; rd_e = 3; rs1_d = 3;
    step(4'b0111, 4'b0100, 1, 0, 2'b10, 2'b00, 0, 0, 2, 0);
    clear_in();
    // Flush overrides a concurrent load-use
    PCSrc_e = 1; load_e = 1; rd_e = 5; rs1_d = 5;
    step(4'b1111, 4'b1100, 0, 0, 2'b00, 2'b00, 0, 0, 3, 0);
    clear_in();
    step(4'b1111, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0, 3, 1);
    // Memory stall 3 cycles beats flush and load-use
    mem_access_m = 1; dmem_ready = 0; PCSrc_e = 1; load_e = 1; rd_e = 5; rs1_d = 5;
    for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 1, 1, 2'b00, 2'b00, 0, k, 3, 1);
    PCSrc_e = 0; load_e = 0; dmem_ready = 1;
    step(4'b1111, 4'b0000, 0, 1, 2'b00, 2'b00, 0, 3, 3, 1);
    // Zero-latency access from IDLE
    step(4'b1111, 4'b0000, 0, 1, 2'b00, 2'b00, 0, 3, 3, 1);
    // Timeout: 17 stalled cycles then HALT
    dmem_ready = 0;
    for (int k = 1; k <= 17; k++) step(4'b0000, 4'b0000, 1, 1, 2'b00, 2'b00, 0, 3 + k - 1, 3, 1);
    step(4'b0000, 4'b0000, 1, 0, 2'b00, 2'b00, 1, 20, 3, 1);
    dmem_ready = 1; PCSrc_e = 1; rs1_e = 7; rd_m = 7; RegWrite_m = 1;
    step(4'b0000, 4'b0000, 1, 0, 2'b10, 2'b00, 1, 20, 3, 1);
    step(4'b0000, 4'b0000, 1, 0, 2'b10, 2'b00, 1, 20, 3, 1);
    // Only reset leaves HALT
    rst_n = 1'b0; clear_in(); mem_access_m = 1;
    @(posedge clk); #1;
    step(4'b1111, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    rst_n = 1'b1; clear_in();
    step(4'b1111, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    mem_access_m = 1; dmem_ready = 0;
    step(4'b0000, 4'b0000, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    dmem_ready = 1;
    step(4'b1111, 4'b0000, 0, 1, 2'b00, 2'b00, 0, 1, 0, 0);
    clear_in();
    begin
      int guard = 0;
      while (sb.size() > 0 && guard < 5) begin
        @(posedge clk); #1;
        guard++;
      end
      if (sb.size() > 0) begin
        failures++;
        $display("FAIL drain actual=%0d expected=0", sb.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
